dti_fifo_rd_stream: RTL and testbench

- Read-side drain engine for the dti async FIFO. Runs entirely in the FIFO read-clock domain.
- Pops first-word-fall-through words from the FIFO read port and presents them on a valid/ready stream through a registered 2-entry buffer. No combinational path from m_ready to fifo_rd_req.
- Also provides flush/drain, a read-error monitor and a transfer counter for downstream status registers.

---
 rtl/dti_fifo_rd_skid_buf.sv | 93 +++++++++
 rtl/dti_fifo_rd_stream.sv | 78 +++++++
 tb/tb_dti_fifo_rd_stream.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dti_fifo_rd_skid_buf.sv
// Two-entry head/tail register buffer that sits between the FIFO read port
// and the output stream. The head register drives m_data directly, so the
// stream output is fully registered.
module dti_fifo_rd_skid_buf #(
  parameter int DATA_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  logic [1:0]            occ_nxt;
  logic [DATA_WIDTH-1:0] head_q, head_nxt;
  logic [DATA_WIDTH-1:0] tail_q, tail_nxt;
  logic                  valid_q;

  // Next-state for occupancy and the two entries. A push that coincides with
  // a pop at occupancy one replaces the head, so occupancy stays at one.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    occ_nxt  = occ;
    head_nxt = head_q;
    tail_nxt = tail_q;
    if (clear) begin
      occ_nxt = OCC_EMPTY;
    end else begin
      unique case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head_nxt = push_data;
            occ_nxt  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          unique case ({push, pop})
            2'b11: head_nxt = push_data;
            2'b10: begin
              tail_nxt = push_data;
              occ_nxt  = OCC_FULL;
            end
            2'b01: occ_nxt = OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_FULL: begin
          // The pop rule never pushes at full, so only the pop matters here.
          if (pop) begin
            head_nxt = tail_q;
            occ_nxt  = OCC_ONE;
          end
        end
        default: occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy, registered valid and the head entry (which is m_data).
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of evaluation order.
    if (!reset_n) begin
      occ     <= OCC_EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      occ     <= occ_nxt;
      valid_q <= (occ_nxt != OCC_EMPTY);
      head_q  <= head_nxt;
    end
  end

  // Tail entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the tail is plain storage that is only read when occ says it is
    // full, so it carries no reset.
    tail_q <= tail_nxt;
  end

  assign valid     = valid_q;
  assign head_data = head_q;

endmodule

// File: rtl/dti_fifo_rd_stream.sv
// Read-side drain engine for the dti async FIFO (read-clock domain only).
// Pops FWFT words into a registered two-entry buffer and streams them out;
// also handles flush, read-error monitoring and a beat counter.
module dti_fifo_rd_stream #(
  parameter int DATA_WIDTH = 21,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  fifo_rd_req,
  input  logic [DATA_WIDTH-1:0] fifo_rd_dout,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_rd_error,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  err_flag,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0] occ;
  logic       buf_full;
  logic       push;
  logic       accept;

  // Pop depends only on registered occupancy and FIFO status, never on
  // m_ready. During flush the FIFO is drained regardless of buffer space.
  assign buf_full    = (occ == 2'd2);
  assign fifo_rd_req = !fifo_rd_empty && (flush || !buf_full);
  assign push        = fifo_rd_req && !flush;
  assign accept      = m_valid && m_ready && !flush;
  assign busy        = (occ != 2'd0) || !fifo_rd_empty;

  dti_fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (push),
    .push_data (fifo_rd_dout),
    .pop       (accept),
    .valid     (m_valid),
    .head_data (m_data),
    .occ       (occ)
  );

  // Sticky error flag and saturating error counter; a clear coinciding with
  // a new error leaves exactly that one error recorded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      err_flag <= fifo_rd_error;
      err_cnt  <= CNT_WIDTH'(fifo_rd_error);
    end else if (fifo_rd_error) begin
      err_flag <= 1'b1;
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Wrapping count of beats accepted by the sink.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt <= '0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dti_fifo_rd_stream.sv
// Bench for dti_fifo_rd_stream: a queue-based FIFO and stream model, checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_dti_fifo_rd_stream;

  localparam int DW = 21;
  localparam int CW = 16;
  typedef logic [DW-1:0] word_t;

  logic          clk;
  logic          reset_n;
  logic          fifo_rd_req, fifo_rd_req_s;
  word_t         fifo_rd_dout;
  logic          fifo_rd_empty;
  logic          fifo_rd_error;
  logic          m_valid, m_valid_s;
  logic          m_ready;
  word_t         m_data, m_data_s;
  logic          flush;
  logic          err_clr;
  logic          err_flag, err_flag_s;
  logic [CW-1:0] err_cnt, xfer_cnt;
  logic [1:0]    err_cnt_s, xfer_cnt_s;
  logic          busy, busy_s;

  dti_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .fifo_rd_req(fifo_rd_req),
    .fifo_rd_dout(fifo_rd_dout), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_error(fifo_rd_error), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .flush(flush), .err_clr(err_clr), .err_flag(err_flag),
    .err_cnt(err_cnt), .xfer_cnt(xfer_cnt), .busy(busy)
  );

  // Narrow-counter instance for saturation and wrap behaviour.
  dti_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .fifo_rd_req(fifo_rd_req_s),
    .fifo_rd_dout(fifo_rd_dout), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_error(fifo_rd_error), .m_valid(m_valid_s), .m_ready(m_ready),
    .m_data(m_data_s), .flush(flush), .err_clr(err_clr), .err_flag(err_flag_s),
    .err_cnt(err_cnt_s), .xfer_cnt(xfer_cnt_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state.
  word_t fifo_q[$];
  word_t exp_q[$];
  word_t log_q[$];
  word_t sent_q[$];
  int    xfer_exp = 0;
  bit    err_flag_exp = 0;
  int    err_cnt_exp = 0;
  int    err_cnt_s_exp = 0;
  int    dut_pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_rd_empty = (fifo_q.size() == 0);
    fifo_rd_dout  = fifo_rd_empty ? '0 : fifo_q[0];
  endtask

  // One clock cycle, entered at a falling edge with inputs already set.
  task automatic cycle();
    bit    req_m, acc_m, err_in, clr_in, flush_in;
    word_t head_word;
    drive_fifo();
    #1;
    flush_in = flush;
    err_in   = fifo_rd_error;
    clr_in   = err_clr;
    req_m    = !fifo_rd_empty && (flush_in || exp_q.size() < 2);
    acc_m    = !flush_in && exp_q.size() != 0 && m_ready;
    check("fifo_rd_req", fifo_rd_req, req_m);
    check("fifo_rd_req_small", fifo_rd_req_s, req_m);
    if (fifo_rd_req) dut_pops++;
    if (acc_m) log_q.push_back(exp_q[0]);
    @(posedge clk);
    #1;
    head_word = '0;
    if (req_m) head_word = fifo_q.pop_front();
    if (flush_in) exp_q.delete();
    else begin
      if (acc_m) begin
        void'(exp_q.pop_front());
        xfer_exp++;
      end
      if (req_m) exp_q.push_back(head_word);
    end
    if (clr_in) begin
      err_flag_exp  = err_in;
      err_cnt_exp   = int'(err_in);
      err_cnt_s_exp = int'(err_in);
    end else if (err_in) begin
      err_flag_exp = 1;
      if (err_cnt_exp < 65535) err_cnt_exp++;
      if (err_cnt_s_exp < 3) err_cnt_s_exp++;
    end
    drive_fifo();
    #1;
    check("m_valid", m_valid, exp_q.size() != 0);
    check("m_valid_small", m_valid_s, exp_q.size() != 0);
    if (exp_q.size() != 0) check("m_data", m_data, exp_q[0]);
    check("xfer_cnt", xfer_cnt, xfer_exp % 65536);
    check("xfer_cnt_small", xfer_cnt_s, xfer_exp % 4);
    check("err_flag", err_flag, err_flag_exp);
    check("err_cnt", err_cnt, err_cnt_exp);
    check("err_cnt_small", err_cnt_s, err_cnt_s_exp);
    check("busy", busy, (exp_q.size() != 0) || (fifo_q.size() != 0));
    @(negedge clk);
  endtask

  initial begin
    int saved_xfer;
    int order_errs;
    reset_n = 1'b0;
    m_ready = 1'b0;
    flush = 1'b0;
    err_clr = 1'b0;
    fifo_rd_error = 1'b0;
    drive_fifo();
    #2;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_xfer_cnt", xfer_cnt, 0);
    check("reset_err_flag", err_flag, 0);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Preloaded words with an always-ready sink.
    for (int i = 1; i <= 4; i++) fifo_q.push_back(word_t'(i));
    m_ready = 1'b1;
    dut_pops = 0;
    log_q.delete();
    for (int i = 0; i < 6; i++) cycle();
    check("t1_pops", dut_pops, 4);
    check("t1_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t1_data", log_q[i], i + 1);
    check("t1_xfer_cnt", xfer_cnt, 4);
    check("t1_busy", busy, 0);

    // Backpressure: buffer fills to two, then releases in order.
    m_ready = 1'b0;
    for (int i = 'h0A; i <= 'h0E; i++) fifo_q.push_back(word_t'(i));
    dut_pops = 0;
    log_q.delete();
    for (int i = 0; i < 4; i++) cycle();
    check("t2_pops", dut_pops, 2);
    check("t2_hold_data", m_data, 'h0A);
    check("t2_hold_valid", m_valid, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("t2_count", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) check("t2_data", log_q[i], 'h0A + i);

    // Random traffic and random sink readiness.
    log_q.delete();
    sent_q.delete();
    saved_xfer = xfer_exp;
    for (int c = 0; c < 8000 && log_q.size() < 1000; c++) begin
      if (sent_q.size() < 1000 && $urandom_range(0, 1) == 1) begin
        word_t w;
        w = word_t'($urandom);
        fifo_q.push_back(w);
        sent_q.push_back(w);
      end
      m_ready = $urandom_range(0, 1) == 1;
      cycle();
    end
    check("t3_count", log_q.size(), 1000);
    order_errs = 0;
    for (int i = 0; i < 1000 && i < log_q.size(); i++)
      if (log_q[i] !== sent_q[i]) order_errs++;
    check("t3_order_errs", order_errs, 0);
    check("t3_xfer_cnt", xfer_cnt, (saved_xfer + 1000) % 65536);

    // Flush with a full buffer and three words left in the FIFO.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(word_t'('h100 + i));
    cycle();
    cycle();
    check("t4_fifo_left", fifo_q.size(), 3);
    saved_xfer = xfer_exp;
    flush = 1'b1;
    m_ready = 1'b1;
    cycle();
    check("t4_valid_dropped", m_valid, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("t4_fifo_empty", fifo_rd_empty, 1);
    check("t4_xfer_unchanged", xfer_cnt, saved_xfer % 65536);
    flush = 1'b0;
    fifo_q.push_back(word_t'('h155));
    log_q.delete();
    for (int i = 0; i < 3; i++) cycle();
    check("t4_first_beat_count", log_q.size(), 1);
    if (log_q.size() != 0) check("t4_first_beat", log_q[0], 'h155);

    // Error monitor.
    fifo_rd_error = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    fifo_rd_error = 1'b0;
    check("t5_err_flag", err_flag, 1);
    check("t5_err_cnt3", err_cnt, 3);
    fifo_rd_error = 1'b1;
    err_clr = 1'b1;
    cycle();
    check("t5_clr_and_err", err_cnt, 1);
    check("t5_clr_and_err_flag", err_flag, 1);
    fifo_rd_error = 1'b0;
    cycle();
    err_clr = 1'b0;
    check("t5_clr_cnt", err_cnt, 0);
    check("t5_clr_flag", err_flag, 0);
    fifo_rd_error = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    fifo_rd_error = 1'b0;
    check("t5_small_saturated", err_cnt_s, 3);
    check("t5_big_cnt5", err_cnt, 5);

    // Asynchronous reset with a full buffer.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(word_t'('h1A0 + i));
    cycle();
    cycle();
    check("t6_pre_valid", m_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", m_valid, 0);
    check("t6_async_err_cnt", err_cnt, 0);
    check("t6_async_xfer_cnt", xfer_cnt, 0);
    check("t6_async_err_flag", err_flag, 0);
    exp_q.delete();
    xfer_exp = 0;
    err_flag_exp = 0;
    err_cnt_exp = 0;
    err_cnt_s_exp = 0;
    @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b1;
    log_q.delete();
    for (int i = 0; i < 4; i++) cycle();
    check("t6_after_reset_count", log_q.size(), 1);
    if (log_q.size() != 0) check("t6_after_reset_word", log_q[0], 'h1A2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
